// File: rtl/operator_input_hub_pkg.sv
// rtl/operator_input_hub_pkg.sv - shared key codes, stand modes, entry states and BCD helper
package operator_input_hub_pkg;

  localparam logic [3:0] KEY_MODE   = 4'hA;
  localparam logic [3:0] KEY_SIGN   = 4'hB;
  localparam logic [3:0] KEY_CLEAR  = 4'hC;
  localparam logic [3:0] KEY_FIELD  = 4'hD;
  localparam logic [3:0] KEY_COMMIT = 4'hE;
  localparam logic [3:0] KEY_CANCEL = 4'hF;

  localparam logic [1:0] MODE_ANGLE_DEMANDED = 2'd0;
  localparam logic [1:0] MODE_SINE           = 2'd1;
  localparam logic [1:0] MODE_AUX2           = 2'd2;
  localparam logic [1:0] MODE_AUX3           = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY_ANGLE,
    ST_ENTRY_AMPL,
    ST_ENTRY_FREQ
  } entry_state_e;

  // Two packed BCD digits to binary; digits are 0-9 so the result is at most 99.
  function automatic logic [7:0] bcd2bin(input logic [7:0] bcd);
    bcd2bin = (8'(bcd[7:4]) * 8'd10) + 8'(bcd[3:0]);
  endfunction

endpackage

// File: rtl/operator_input_hub_keypad_scanner.sv
// rtl/operator_input_hub_keypad_scanner.sv - keypad row scan, column synchroniser, frame decode, debounce
module keypad_scanner #(
  parameter int NUM_ROWS        = 4,
  parameter int NUM_COLS        = 4,
  parameter int SCAN_PRESCALE   = 50_000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                clk_i,
  input  logic                nReset_i,
  input  logic                enable_i,
  input  logic [NUM_COLS-1:0] cols_i,
  output logic [NUM_ROWS-1:0] rows_o,
  output logic                key_valid_o,
  output logic [3:0]          key_code_o
);

  localparam int PW = $clog2(SCAN_PRESCALE + 1);
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);

  logic [PW-1:0]       pre_q;
  logic [RW-1:0]       row_q;
  logic [NUM_COLS-1:0] sync1_q, sync2_q;
  logic [1:0]          frame_hits_q;
  logic [3:0]          frame_code_q;
  logic                pressed_q, pressed_d;
  logic [3:0]          cand_q, cand_d;
  logic [DW-1:0]       deb_q, deb_d;
  logic                key_valid_q;
  logic [3:0]          key_code_q;

  logic       dwell_end, frame_end, frame_key, fire;
  logic [1:0] row_hits, tot_hits;
  logic [2:0] hit_sum;
  logic [3:0] row_col, frame_code;

  assign dwell_end = (pre_q == PW'(SCAN_PRESCALE - 1));
  assign frame_end = dwell_end && (row_q == RW'(NUM_ROWS - 1));

  always_comb begin
    rows_o = '1;
    if (enable_i) rows_o[row_q] = 1'b0;
  end

  // Low-column count saturates at 2: anything beyond one key in a frame is a ghost.
  always_comb begin
    row_hits = 2'd0;
    row_col  = 4'd0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (!sync2_q[c]) begin
        row_col = 4'(c);
        if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
      end
    end
  end

  assign hit_sum    = {1'b0, frame_hits_q} + {1'b0, row_hits};
  assign tot_hits   = (hit_sum > 3'd1) ? 2'd2 : hit_sum[1:0];
  assign frame_code = (row_hits != 2'd0) ? 4'(int'(row_q) * NUM_COLS + int'(row_col)) : frame_code_q;
  assign frame_key  = (tot_hits == 2'd1);

  always_comb begin
    pressed_d = pressed_q;
    cand_d    = cand_q;
    deb_d     = deb_q;
    fire      = 1'b0;
    if (frame_end) begin
      if (!pressed_q) begin
        if (frame_key) begin
          if (frame_code == cand_q) begin
            deb_d = deb_q + DW'(1);
          end else begin
            cand_d = frame_code;
            deb_d  = DW'(1);
          end
          if (deb_d == DW'(DEBOUNCE_FRAMES)) begin
            fire      = 1'b1;
            pressed_d = 1'b1;
            deb_d     = '0;
          end
        end else begin
          deb_d = '0;
        end
      end else begin
        if (!frame_key) begin
          deb_d = deb_q + DW'(1);
          if (deb_d == DW'(DEBOUNCE_FRAMES)) begin
            pressed_d = 1'b0;
            deb_d     = '0;
          end
        end else begin
          deb_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge nReset_i) begin
    if (!nReset_i) begin
      pre_q        <= '0;
      row_q        <= '0;
      sync1_q      <= '1;
      sync2_q      <= '1;
      frame_hits_q <= '0;
      frame_code_q <= '0;
      pressed_q    <= 1'b0;
      cand_q       <= '0;
      deb_q        <= '0;
      key_valid_q  <= 1'b0;
      key_code_q   <= '0;
    end else begin
      sync1_q <= cols_i;
      sync2_q <= sync1_q;
      if (!enable_i) begin
        pre_q        <= '0;
        row_q        <= '0;
        frame_hits_q <= '0;
        frame_code_q <= '0;
        pressed_q    <= 1'b0;
        cand_q       <= '0;
        deb_q        <= '0;
        key_valid_q  <= 1'b0;
      end else begin
        key_valid_q <= fire;
        if (fire) key_code_q <= cand_d;
        pressed_q <= pressed_d;
        cand_q    <= cand_d;
        deb_q     <= deb_d;
        if (dwell_end) begin
          pre_q        <= '0;
          row_q        <= (row_q == RW'(NUM_ROWS - 1)) ? '0 : row_q + RW'(1);
          frame_hits_q <= frame_end ? 2'd0 : tot_hits;
          frame_code_q <= frame_end ? 4'd0 : frame_code;
        end else begin
          pre_q <= pre_q + PW'(1);
        end
      end
    end
  end

  assign key_valid_o = key_valid_q;
  assign key_code_o  = key_code_q;

endmodule

// File: rtl/operator_input_hub.sv
// rtl/operator_input_hub.sv - keypad-driven setpoint entry for mode, angle and sine amplitude/frequency
module operator_input_hub
  import operator_input_hub_pkg::*;
#(
  parameter int NUM_ROWS             = 4,
  parameter int NUM_COLS             = 4,
  parameter int SCAN_PRESCALE        = 50_000,
  parameter int DEBOUNCE_FRAMES      = 4,
  parameter int ANGLE_RESOLUTION_INT = 9,
  parameter int ANGLE_DEG_SHAFT_MAX  = 37,
  parameter int AMP_DEG_RESOLUTION   = 6,
  parameter int FREQ_SINE_MSB        = 7
) (
  input  logic                            clk_i,
  input  logic                            nReset_i,
  input  logic                            enable_i,
  input  logic [NUM_COLS-1:0]             cols_i,
  output logic [NUM_ROWS-1:0]             rows_o,
  output logic                            key_valid_o,
  output logic [3:0]                      key_code_o,
  output logic [1:0]                      mode_o,
  output logic [ANGLE_RESOLUTION_INT-1:0] angle_demanded_o,
  output logic [AMP_DEG_RESOLUTION-1:0]   ampl_sine_o,
  output logic [FREQ_SINE_MSB:0]          freq_sine_o,
  output logic                            entry_active_o,
  output logic [7:0]                      entry_BCD_o
);

  localparam int MAG_W  = ANGLE_RESOLUTION_INT - 1;
  localparam int FREQ_W = FREQ_SINE_MSB + 1;

  logic       key_valid;
  logic [3:0] key_code;
  logic       is_digit;

  entry_state_e state_q, state_d;
  logic [7:0]                      buf_q, buf_d;
  logic                            sign_q, sign_d;
  logic [7:0]                      amp_stage_q, amp_stage_d;
  logic [1:0]                      mode_q, mode_d;
  logic [ANGLE_RESOLUTION_INT-1:0] angle_q, angle_d;
  logic [AMP_DEG_RESOLUTION-1:0]   ampl_q, ampl_d;
  logic [FREQ_W-1:0]               freq_q, freq_d;

  logic [7:0]                    ang_bin;
  logic [MAG_W-1:0]              ang_mag;
  logic [AMP_DEG_RESOLUTION-1:0] amp_clamped;

  keypad_scanner #(
    .NUM_ROWS       (NUM_ROWS),
    .NUM_COLS       (NUM_COLS),
    .SCAN_PRESCALE  (SCAN_PRESCALE),
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_scanner (
    .clk_i      (clk_i),
    .nReset_i   (nReset_i),
    .enable_i   (enable_i),
    .cols_i     (cols_i),
    .rows_o     (rows_o),
    .key_valid_o(key_valid),
    .key_code_o (key_code)
  );

  assign is_digit    = (key_code <= 4'd9);
  assign ang_bin     = bcd2bin(buf_q);
  assign ang_mag     = (ang_bin > 8'(ANGLE_DEG_SHAFT_MAX)) ? MAG_W'(ANGLE_DEG_SHAFT_MAX) : MAG_W'(ang_bin);
  assign amp_clamped = (amp_stage_q > 8'(ANGLE_DEG_SHAFT_MAX)) ? AMP_DEG_RESOLUTION'(ANGLE_DEG_SHAFT_MAX)
                                                               : AMP_DEG_RESOLUTION'(amp_stage_q);

  always_ff @(posedge clk_i or negedge nReset_i) begin
    if (!nReset_i) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = ST_IDLE;
    end else if (key_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (key_code == KEY_FIELD) begin
            if (mode_q == MODE_ANGLE_DEMANDED) state_d = ST_ENTRY_ANGLE;
            else if (mode_q == MODE_SINE)      state_d = ST_ENTRY_AMPL;
          end
        end
        ST_ENTRY_ANGLE: begin
          if (key_code == KEY_COMMIT || key_code == KEY_CANCEL) state_d = ST_IDLE;
        end
        ST_ENTRY_AMPL: begin
          if (key_code == KEY_CANCEL) state_d = ST_IDLE;
          else if (key_code == KEY_COMMIT || key_code == KEY_FIELD) state_d = ST_ENTRY_FREQ;
        end
        ST_ENTRY_FREQ: begin
          if (key_code == KEY_CANCEL) state_d = ST_IDLE;
          else if (key_code == KEY_COMMIT && buf_q != 8'h00) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    buf_d       = buf_q;
    sign_d      = sign_q;
    amp_stage_d = amp_stage_q;
    mode_d      = mode_q;
    angle_d     = angle_q;
    ampl_d      = ampl_q;
    freq_d      = freq_q;
    if (!enable_i) begin
      buf_d       = 8'h00;
      sign_d      = 1'b0;
      amp_stage_d = 8'h00;
    end else if (key_valid) begin
      if (state_q == ST_IDLE) begin
        if (key_code == KEY_MODE) mode_d = mode_q + 2'd1;
      end else begin
        if (is_digit) buf_d = {buf_q[3:0], key_code};
        if (key_code == KEY_CLEAR) buf_d = 8'h00;
        if (key_code == KEY_SIGN && state_q == ST_ENTRY_ANGLE) sign_d = ~sign_q;
        if (key_code == KEY_COMMIT && state_q == ST_ENTRY_ANGLE)
          angle_d = {sign_q & (ang_mag != '0), ang_mag};
        if ((key_code == KEY_COMMIT || key_code == KEY_FIELD) && state_q == ST_ENTRY_AMPL)
          amp_stage_d = ang_bin;
        if (key_code == KEY_COMMIT && state_q == ST_ENTRY_FREQ && buf_q != 8'h00) begin
          freq_d = FREQ_W'(buf_q);
          ampl_d = amp_clamped;
        end
      end
      // Any state change starts the next field (or IDLE) with a blank, positive buffer.
      if (state_d != state_q) begin
        buf_d  = 8'h00;
        sign_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge nReset_i) begin
    if (!nReset_i) begin
      buf_q       <= 8'h00;
      sign_q      <= 1'b0;
      amp_stage_q <= 8'h00;
      mode_q      <= MODE_ANGLE_DEMANDED;
      angle_q     <= '0;
      ampl_q      <= '0;
      freq_q      <= FREQ_W'(1);
    end else begin
      buf_q       <= buf_d;
      sign_q      <= sign_d;
      amp_stage_q <= amp_stage_d;
      mode_q      <= mode_d;
      angle_q     <= angle_d;
      ampl_q      <= ampl_d;
      freq_q      <= freq_d;
    end
  end

  always_comb begin
    entry_active_o = (state_q != ST_IDLE);
  end

  assign key_valid_o      = key_valid;
  assign key_code_o       = key_code;
  assign mode_o           = mode_q;
  assign angle_demanded_o = angle_q;
  assign ampl_sine_o      = ampl_q;
  assign freq_sine_o      = freq_q;
  assign entry_BCD_o      = buf_q;

endmodule

// File: tb/tb_operator_input_hub.sv
// tb/tb_operator_input_hub.sv - keypad-level bench with a behavioural setpoint-entry model
module tb_operator_input_hub;

  localparam int PRESCALE = 4;
  localparam int FRAME    = 4 * PRESCALE;
  localparam int HOLD     = 6;

  logic        clk = 1'b0;
  logic        nReset, enable;
  logic [3:0]  cols, rows;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [1:0]  mode;
  logic [8:0]  angle;
  logic [5:0]  ampl;
  logic [7:0]  freq;
  logic        entry_active;
  logic [7:0]  entry_bcd;
  logic [15:0] held = '0;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  logic [3:0] last_code = '0;

  // Behavioural model: state 0 idle, 1 angle, 2 amplitude, 3 frequency.
  int         m_state, m_tens, m_ones, m_sign, m_amp_stage;
  logic [1:0] m_mode;
  logic [8:0] m_angle;
  logic [5:0] m_ampl;
  logic [7:0] m_freq;

  wire [33:0] dut_vec = {mode, angle, ampl, freq, entry_active, entry_bcd};

  operator_input_hub #(.SCAN_PRESCALE(PRESCALE)) dut (
    .clk_i           (clk),
    .nReset_i        (nReset),
    .enable_i        (enable),
    .cols_i          (cols),
    .rows_o          (rows),
    .key_valid_o     (key_valid),
    .key_code_o      (key_code),
    .mode_o          (mode),
    .angle_demanded_o(angle),
    .ampl_sine_o     (ampl),
    .freq_sine_o     (freq),
    .entry_active_o  (entry_active),
    .entry_BCD_o     (entry_bcd)
  );

  always #5 clk = ~clk;

  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!rows[r] && held[r*4+c]) cols[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid) begin
      pulse_cnt = pulse_cnt + 1;
      last_code = key_code;
    end
  end

  function automatic logic [33:0] exp_vec();
    logic [7:0] bcd;
    bcd = (m_state == 0) ? 8'h00 : 8'(m_tens * 16 + m_ones);
    return {m_mode, m_angle, m_ampl, m_freq, (m_state != 0), bcd};
  endfunction

  task automatic model_reset();
    m_state = 0; m_tens = 0; m_ones = 0; m_sign = 0; m_amp_stage = 0;
    m_mode = 2'd0; m_angle = 9'd0; m_ampl = 6'd0; m_freq = 8'h01;
  endtask

  task automatic model_enter(input int s);
    m_state = s; m_tens = 0; m_ones = 0; m_sign = 0;
  endtask

  task automatic model_key(input int k);
    int v;
    v = m_tens * 10 + m_ones;
    if (v > 37) v = 37;
    if (m_state == 0) begin
      if (k == 10) m_mode = m_mode + 2'd1;
      else if (k == 13 && m_mode == 2'd0) model_enter(1);
      else if (k == 13 && m_mode == 2'd1) model_enter(2);
    end else if (k <= 9) begin
      m_tens = m_ones; m_ones = k;
    end else if (k == 11) begin
      if (m_state == 1) m_sign = 1 - m_sign;
    end else if (k == 12) begin
      m_tens = 0; m_ones = 0;
    end else if (k == 15) begin
      model_enter(0);
    end else if (k == 13) begin
      if (m_state == 2) begin m_amp_stage = m_tens * 10 + m_ones; model_enter(3); end
    end else if (k == 14) begin
      if (m_state == 1) begin
        m_angle = {(m_sign != 0 && v != 0), 8'(v)};
        model_enter(0);
      end else if (m_state == 2) begin
        m_amp_stage = m_tens * 10 + m_ones;
        model_enter(3);
      end else if (m_tens != 0 || m_ones != 0) begin
        m_freq = 8'(m_tens * 16 + m_ones);
        m_ampl = 6'((m_amp_stage > 37) ? 37 : m_amp_stage);
        model_enter(0);
      end
    end
  endtask

  task automatic hold_keys(input logic [15:0] mask, input int cycles);
    @(posedge clk); #1 held = mask;
    repeat (cycles) @(posedge clk);
    #1 held = '0;
    repeat (HOLD * FRAME) @(posedge clk);
  endtask

  task automatic press(input int k);
    logic [15:0] m;
    m = '0;
    m[k] = 1'b1;
    hold_keys(m, HOLD * FRAME);
    model_key(k);
  endtask

  task automatic test_reset();
    checks++;
    if (rows !== 4'b1110) begin errors++; $display("FAIL reset_rows: got %b expected %b", rows, 4'b1110); end
    checks++;
    if (key_valid !== 1'b0 || key_code !== 4'd0) begin
      errors++; $display("FAIL reset_key: got valid=%b code=%h expected 0/0", key_valid, key_code);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin errors++; $display("FAIL reset_outputs: got %h expected %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_debounce();
    int prev;
    prev = pulse_cnt;
    press(5);
    checks++;
    if (pulse_cnt !== prev + 1) begin errors++; $display("FAIL press_count: got %0d expected %0d", pulse_cnt - prev, 1); end
    checks++;
    if (last_code !== 4'd5) begin errors++; $display("FAIL press_code_at_pulse: got %h expected 5", last_code); end
    checks++;
    if (key_code !== 4'd5) begin errors++; $display("FAIL press_code_held: got %h expected 5", key_code); end
  endtask

  task automatic test_short_press();
    int prev;
    prev = pulse_cnt;
    hold_keys(16'h0020, 3 * FRAME - 4);
    checks++;
    if (pulse_cnt !== prev) begin errors++; $display("FAIL short_press: got %0d pulses expected 0", pulse_cnt - prev); end
  endtask

  task automatic test_ghost();
    int prev;
    prev = pulse_cnt;
    hold_keys(16'h0060, HOLD * FRAME);
    checks++;
    if (pulse_cnt !== prev) begin errors++; $display("FAIL ghost: got %0d pulses expected 0", pulse_cnt - prev); end
  endtask

  task automatic test_angle_clamp();
    press(13); press(11); press(4); press(2); press(14);
    checks++;
    if (angle !== 9'h125) begin errors++; $display("FAIL angle_clamp: got %h expected %h", angle, 9'h125); end
    checks++;
    if (dut_vec !== exp_vec()) begin errors++; $display("FAIL angle_clamp_all: got %h expected %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_angle_drop();
    press(13); press(1); press(2); press(3);
    checks++;
    if (entry_bcd !== 8'h23 || entry_active !== 1'b1) begin
      errors++; $display("FAIL angle_entry_bcd: got %h/%b expected 23/1", entry_bcd, entry_active);
    end
    press(14);
    checks++;
    if (angle !== 9'd23 || entry_active !== 1'b0) begin
      errors++; $display("FAIL angle_drop: got %h/%b expected %h/0", angle, entry_active, 9'd23);
    end
  endtask

  task automatic test_sine();
    press(10); press(13); press(2); press(0); press(13); press(0); press(0); press(14);
    checks++;
    if (entry_active !== 1'b1 || freq !== 8'h01) begin
      errors++; $display("FAIL freq_reject: got active=%b freq=%h expected 1/01", entry_active, freq);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin errors++; $display("FAIL freq_reject_all: got %h expected %h", dut_vec, exp_vec()); end
    press(0); press(5); press(14);
    checks++;
    if (ampl !== 6'd20 || freq !== 8'h05 || entry_active !== 1'b0) begin
      errors++; $display("FAIL sine_commit: got ampl=%0d freq=%h active=%b expected 20/05/0", ampl, freq, entry_active);
    end
  endtask

  task automatic test_enable_mid_entry();
    press(13); press(7);
    checks++;
    if (entry_bcd !== 8'h07 || entry_active !== 1'b1) begin
      errors++; $display("FAIL enable_pre: got %h/%b expected 07/1", entry_bcd, entry_active);
    end
    @(posedge clk); #1 enable = 1'b0;
    @(posedge clk); #1;
    model_enter(0);
    checks++;
    if (rows !== 4'hF) begin errors++; $display("FAIL enable_rows: got %h expected F", rows); end
    checks++;
    if (dut_vec !== exp_vec()) begin errors++; $display("FAIL enable_outputs: got %h expected %h", dut_vec, exp_vec()); end
    repeat (10) @(posedge clk);
    #1 enable = 1'b1;
  endtask

  task automatic test_random();
    int prev, k, r;
    for (int i = 0; i < 50; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5) k = $urandom_range(0, 9);
      else if (r < 7) k = 13;
      else if (r == 7) k = 14;
      else k = $urandom_range(10, 15);
      prev = pulse_cnt;
      press(k);
      checks++;
      if (pulse_cnt !== prev + 1 || last_code !== k[3:0]) begin
        errors++; $display("FAIL rand_key[%0d]: got %0d pulses code %h expected 1 code %h", i, pulse_cnt - prev, last_code, k[3:0]);
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL rand_outputs[%0d] key %h: got %h expected %h", i, k[3:0], dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid_entry();
    press(10);
    while (m_mode != 2'd0) press(10);
    press(13); press(3);
    @(negedge clk); #2 nReset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec !== exp_vec()) begin errors++; $display("FAIL async_reset: got %h expected %h", dut_vec, exp_vec()); end
    checks++;
    if (rows !== 4'b1110 || key_code !== 4'd0) begin
      errors++; $display("FAIL async_reset_scan: got %b/%h expected 1110/0", rows, key_code);
    end
    repeat (3) @(posedge clk);
    #1 nReset = 1'b1;
  endtask

  initial begin
    nReset = 1'b0;
    enable = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    nReset = 1'b1;
    test_debounce();
    test_short_press();
    test_ghost();
    test_angle_clamp();
    test_angle_drop();
    test_sine();
    test_enable_mid_entry();
    test_random();
    test_reset_mid_entry();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
